// File: rtl/mc_pkg.sv
// Shared definitions for the memory-controller host responder: op codes,
// block geometry and the responder state encoding.
package mc_pkg;

  localparam int BLOCK_BEATS = 16;
  localparam int BLOCK_BYTES = 64;
  localparam int BEAT_W      = $clog2(BLOCK_BEATS);
  localparam int BLK_OFF_W   = $clog2(BLOCK_BYTES);

  typedef logic [BEAT_W-1:0] beat_t;

  localparam beat_t LAST_BEAT = beat_t'(BLOCK_BEATS - 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_READ  = 3'd1,
    OP_WRITE = 3'd2,
    OP_DUMP  = 3'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_FETCH  = 3'd1,
    ST_RD_BEAT   = 3'd2,
    ST_WR_BEAT   = 3'd3,
    ST_DONE      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_e;

  // Unused encodings 4-7 collapse onto NONE so they can never start a transaction.
  function automatic op_e decode_op(input logic [2:0] raw);
    case (raw)
      3'd1:    return OP_READ;
      3'd2:    return OP_WRITE;
      3'd3:    return OP_DUMP;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mc_host_responder_if.sv
// Arbiter-side transaction bus of the host responder.
interface mc_host_responder_if;

  logic [2:0]  op;
  logic [31:0] io_addr;
  logic [31:0] common_data_bus_out;
  logic [63:0] cv_value;
  logic [31:0] common_data_bus_in;
  logic        rd_valid;
  logic        tx_done;

  modport master (
    output op, io_addr, common_data_bus_out, cv_value,
    input  common_data_bus_in, rd_valid, tx_done
  );

  modport slave (
    input  op, io_addr, common_data_bus_out, cv_value,
    output common_data_bus_in, rd_valid, tx_done
  );

endinterface

// File: rtl/mc_word_ram.sv
// Single-port backing store, 32-bit words, one-cycle synchronous read.
module mc_word_ram #(
  parameter  int MEM_WORDS = 4096,
  localparam int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mc_host_responder.sv
// Host-side responder: serves 64-byte block reads/writes and status dumps
// for the memory arbiter out of a local word RAM with a backdoor preload path.
//
//  state        | meaning
//  -------------+-----------------------------------------------------------
//  ST_IDLE      | waiting for op; backdoor preload allowed when op is NONE
//  ST_RD_FETCH  | first RAM read issued, data available next cycle
//  ST_RD_BEAT   | 16 read beats on common_data_bus_in with rd_valid
//  ST_WR_BEAT   | 16 write beats captured from common_data_bus_out
//  ST_DONE      | one-cycle tx_done pulse
//  ST_WAIT_IDLE | hold until the arbiter drops op back to NONE
module mc_host_responder
  import mc_pkg::*;
#(
  parameter int MEM_WORDS = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  mc_host_responder_if.slave     bus,
  input  logic                   ld_en,
  input  logic [31:0]            ld_addr,
  input  logic [31:0]            ld_data,
  output logic [63:0]            dump_cv,
  output logic                   halted
);

  localparam int AW = $clog2(MEM_WORDS);

  state_e        state_q, state_d;
  beat_t         beat_q, beat_d;
  logic [AW-1:0] base_q, base_d;
  logic          is_dump_q, is_dump_d;
  logic [63:0]   dump_cv_q, dump_cv_d;
  logic          halted_q, halted_d;

  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  op_e           op_dec;
  beat_t         rd_next_off;
  logic [AW-1:0] blk_base;
  logic          unused_addr_bits;

  assign op_dec           = decode_op(bus.op);
  assign rd_next_off      = beat_q + beat_t'(1);
  assign blk_base         = AW'({bus.io_addr[31:BLK_OFF_W], {BEAT_W{1'b0}}});
  assign unused_addr_bits = ^bus.io_addr[BLK_OFF_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      base_q    <= '0;
      is_dump_q <= 1'b0;
      dump_cv_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      is_dump_q <= is_dump_d;
      dump_cv_q <= dump_cv_d;
      halted_q  <= halted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    base_d    = base_q;
    is_dump_d = is_dump_q;
    dump_cv_d = dump_cv_q;
    halted_d  = halted_q;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = base_q | AW'(beat_q);
    ram_wdata = bus.common_data_bus_out;

    case (state_q)
      ST_IDLE: begin
        beat_d = '0;
        case (op_dec)
          OP_READ: begin
            state_d   = ST_RD_FETCH;
            base_d    = blk_base;
            is_dump_d = 1'b0;
          end
          OP_WRITE: begin
            state_d   = ST_WR_BEAT;
            base_d    = blk_base;
            is_dump_d = 1'b0;
          end
          OP_DUMP: begin
            state_d   = ST_DONE;
            base_d    = blk_base;
            is_dump_d = 1'b1;
            dump_cv_d = bus.cv_value;
          end
          default: begin
            if (ld_en) begin
              ram_en    = 1'b1;
              ram_we    = 1'b1;
              ram_addr  = AW'(ld_addr);
              ram_wdata = ld_data;
            end
          end
        endcase
      end

      ST_RD_FETCH: begin
        ram_en   = 1'b1;
        ram_addr = base_q;
        state_d  = ST_RD_BEAT;
      end

      // Prefetch the next word while the current one is on the bus.
      ST_RD_BEAT: begin
        ram_en   = 1'b1;
        ram_addr = base_q | AW'(rd_next_off);
        beat_d   = beat_q + beat_t'(1);
        if (beat_q == LAST_BEAT) begin
          state_d = ST_DONE;
        end
      end

      ST_WR_BEAT: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = base_q | AW'(beat_q);
        beat_d   = beat_q + beat_t'(1);
        if (beat_q == LAST_BEAT) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_WAIT_IDLE;
        if (is_dump_q) begin
          halted_d = 1'b1;
        end
      end

      ST_WAIT_IDLE: begin
        if (op_dec == OP_NONE) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  mc_word_ram #(
    .MEM_WORDS (MEM_WORDS)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign bus.rd_valid           = (state_q == ST_RD_BEAT);
  assign bus.tx_done            = (state_q == ST_DONE);
  assign bus.common_data_bus_in = (state_q == ST_RD_BEAT) ? ram_rdata : '0;
  assign dump_cv                = dump_cv_q;
  assign halted                 = halted_q;

endmodule
